bcd_display_scan_ctrl: RTL and testbench

//  Sequencer that drives four multiplexed seven-segment displays from one binary value.
//  - Converts a binary input to 4 BCD digits sequentially (shift-add-3), one bit per clock.
//  - Time-multiplexes the digits onto a single segment bus with one-hot anodes.
//  - Sits between the value source (switches/counter) and the board's 7-seg pins.

---
 rtl/bcd_display_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_bcd_display_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_display_scan_ctrl
//
// Drives four multiplexed seven-segment displays from a single binary value.
// A load request captures the binary input. A shift-add-3 sequencer then
// converts it to four BCD digits, one input bit per clock. After the last
// bit, the digits are copied into the display registers. A free-running scan
// counter steps through the four digits and puts the selected digit onto the
// shared segment bus, with a one-hot active-low anode select.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//    When defined, a digit is blanked if it is zero and every digit above it
//    is also zero. The units digit is never blanked. When undefined, all four
//    digits are always shown.
//
// Parameters
//    N_in      width of the binary input (4..14)
//    N_out     segment bus width, {g,f,e,d,c,b,a}
//    SCAN_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//    clk     in   1      single clock, rising edge
//    rst     in   1      synchronous active-high reset
//    bin_in  in   N_in   binary value, sampled only when a load is accepted
//    load    in   1      conversion request (pulse or level)
//    busy    out  1      conversion in progress; load is ignored meanwhile
//    seg     out  N_out  active-low segments of the selected digit
//    an      out  4      active-low one-hot anode, an[0]=units..an[3]=thousands
// ---------------------------------------------------------------------------
module bcd_display_scan_ctrl #(
   parameter int N_in     = 10,
   parameter int N_out    = 7,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_in-1:0]  bin_in,
   input  logic             load,
   output logic             busy,
   output logic [N_out-1:0] seg,
   output logic [3:0]       an
);

   localparam int          DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]  LAST_BIT = 4'(N_in - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH
   } state_t;

   state_t            state_q;
   state_t            state_nxt;
   logic              start;
   logic              do_shift;
   logic              do_latch;

   logic [N_in-1:0]   bin_q;
   logic [N_in-1:0]   bin_shift;
   logic [15:0]       bcd_q;
   logic [15:0]       bcd_adj;
   logic [15:0]       bcd_shift;
   logic [3:0]        bit_cnt_q;
   logic              ovf_q;
   logic              busy_q;

   logic [15:0]       disp_q;
   logic [15:0]       disp_nxt;
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_nxt;
   logic [1:0]        idx_q;
   logic [1:0]        idx_nxt;
   logic [3:0]        sel_digit;
   logic              blank;
   logic [6:0]        seg_nxt;
   logic [N_out-1:0]  seg_q;
   logic [3:0]        an_q;

   // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
   // Codes above 9 cannot occur and are shown dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // State register for the conversion sequencer. Reset returns it to IDLE,
   // which also aborts a conversion that is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic. A load is only honoured in IDLE, so requests that
   // arrive while busy are dropped rather than queued. SHIFT lasts one cycle
   // per input bit, and LATCH is a single cycle that publishes the digits.
   always_comb begin
      state_nxt = state_q;
      start     = 1'b0;
      do_shift  = 1'b0;
      do_latch  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               start     = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            do_shift = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               state_nxt = LATCH;
            end
         end
         LATCH: begin
            do_latch  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // One shift-add-3 step: every BCD nibble of 5 or more gets 3 added so
   // that the following doubling carries correctly into the next decade.
   // The next binary MSB is then shifted into the BCD units position.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_shift    = bcd_adj << 1;
      bcd_shift[0] = bin_q[N_in-1];
      bin_shift    = bin_q << 1;
   end

   // Conversion datapath. The overflow flag is decided when the value is
   // captured. Only a 14-bit input can exceed 9999, and such a value would
   // not fit in four decades, so the display is clamped to 9999 instead.
   // busy is registered from the next state, so it rises on the accepting
   // edge and falls on the LATCH edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q     <= '0;
         bcd_q     <= '0;
         bit_cnt_q <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         if (start) begin
            bin_q     <= bin_in;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            ovf_q     <= (32'(bin_in) > 32'd9999);
         end else if (do_shift) begin
            bin_q     <= bin_shift;
            bcd_q     <= bcd_shift;
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         busy_q <= (state_nxt != IDLE);
      end
   end

   // Next display contents, scan position and segment pattern. The segment
   // register is fed from the next digit and next index. This means a digit
   // latched on a scan-wrap edge is shown immediately under the new anode,
   // with no stale cycle.
   always_comb begin
      disp_nxt = disp_q;
      if (do_latch) begin
         disp_nxt = ovf_q ? 16'h9999 : bcd_q;
      end

      div_nxt = div_q + DIV_W'(1);
      idx_nxt = idx_q;
      if (div_q == DIV_LAST) begin
         div_nxt = '0;
         idx_nxt = idx_q + 2'd1;
      end

      case (idx_nxt)
         2'd0:    sel_digit = disp_nxt[3:0];
         2'd1:    sel_digit = disp_nxt[7:4];
         2'd2:    sel_digit = disp_nxt[11:8];
         default: sel_digit = disp_nxt[15:12];
      endcase

      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      case (idx_nxt)
         2'd3:    blank = (disp_nxt[15:12] == 4'd0);
         2'd2:    blank = (disp_nxt[15:8] == 8'd0);
         2'd1:    blank = (disp_nxt[15:4] == 12'd0);
         default: blank = 1'b0;
      endcase
`endif

      seg_nxt = blank ? 7'b1111111 : seg_decode(sel_digit);
   end

   // Display registers and the scan counter. These run independently of
   // the sequencer, and all outputs leave the block straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q <= '0;
         div_q  <= '0;
         idx_q  <= 2'd0;
         seg_q  <= N_out'(7'b1000000);
         an_q   <= 4'b1110;
      end else begin
         disp_q <= disp_nxt;
         div_q  <= div_nxt;
         idx_q  <= idx_nxt;
         seg_q  <= N_out'(seg_nxt);
         an_q   <= ~(4'b0001 << idx_nxt);
      end
   end

   assign busy = busy_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scan_ctrl
//
// Self-checking bench for bcd_display_scan_ctrl. It drives two instances,
// one with a 10-bit input and one with a 14-bit input, both using a short
// scan period. A reference model tracks, for each instance, the decimal
// value being shown, the remaining busy time and the number of clocks since
// reset. The expected anode, segments and busy flag are worked out from
// those with plain integer arithmetic. Honours LEADING_ZERO_BLANK_EN in the
// same way as the design.
// ---------------------------------------------------------------------------
module tb_bcd_display_scan_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int NIN [2] = '{10, 14};
   localparam logic [6:0] SEG_TBL [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic        clk;
   logic        rst;
   logic [13:0] bin_v  [2];
   logic        load_v [2];
   logic        busy_w [2];
   logic [6:0]  seg_w  [2];
   logic [3:0]  an_w   [2];

   logic        chk_en;
   int          n_checks;
   int          n_fail;

   int          m_edges [2];
   int          m_left  [2];
   int          m_shown [2];
   int          m_pend  [2];

   bcd_display_scan_ctrl #(
      .N_in     (10),
      .N_out    (7),
      .SCAN_DIV (SCAN_DIV)
   ) dut10 (
      .clk    (clk),
      .rst    (rst),
      .bin_in (bin_v[0][9:0]),
      .load   (load_v[0]),
      .busy   (busy_w[0]),
      .seg    (seg_w[0]),
      .an     (an_w[0])
   );

   bcd_display_scan_ctrl #(
      .N_in     (14),
      .N_out    (7),
      .SCAN_DIV (SCAN_DIV)
   ) dut14 (
      .clk    (clk),
      .rst    (rst),
      .bin_in (bin_v[1]),
      .load   (load_v[1]),
      .busy   (busy_w[1]),
      .seg    (seg_w[1]),
      .an     (an_w[1])
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value differs
   // from the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected segment pattern for scan position idx when the display holds
   // the decimal value shown.
   function automatic logic [6:0] expSeg(input int shown, input int idx);
      int pw;
      pw = 1;
      for (int k = 0; k < idx; k++) pw = pw * 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx > 0 && shown < pw) return 7'b1111111;
`endif
      return SEG_TBL[(shown / pw) % 10];
   endfunction

   // Reference model, updated on each rising edge. A load accepted while idle
   // is busy for N_in+1 clocks, and the new value appears on the edge that
   // ends the busy period. The value is clamped to 9999. Requests made while
   // busy are dropped. Reset clears everything, including the scan position.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_edges[i] <= 0;
            m_left[i]  <= 0;
            m_shown[i] <= 0;
            m_pend[i]  <= 0;
         end else begin
            m_edges[i] <= m_edges[i] + 1;
            if (m_left[i] > 0) begin
               m_left[i] <= m_left[i] - 1;
               if (m_left[i] == 1) m_shown[i] <= m_pend[i];
            end else if (load_v[i]) begin
               m_left[i] <= NIN[i] + 1;
               m_pend[i] <= ((int'(bin_v[i]) & ((1 << NIN[i]) - 1)) > 9999) ?
                            9999 : (int'(bin_v[i]) & ((1 << NIN[i]) - 1));
            end
         end
      end
   end

   // Compares every output of both instances with the model on each falling
   // edge, once the first reset edge has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            int idx;
            idx = (m_edges[i] / SCAN_DIV) % 4;
            checkOutput($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_left[i] > 0));
            checkOutput($sformatf("an%0d", i), 32'(an_w[i]), 32'(4'b1111 ^ (4'b0001 << idx)));
            checkOutput($sformatf("seg%0d", i), 32'(seg_w[i]), 32'(expSeg(m_shown[i], idx)));
         end
      end
   end

   // Waits, within a bounded number of clocks, until the selected instance
   // is idle again.
   task automatic waitIdle(input int inst);
      int n;
      n = 0;
      while ((busy_w[inst] !== 1'b0 || m_left[inst] != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) checkOutput($sformatf("idle_timeout%0d", inst), 32'd1, 32'd0);
   endtask

   // Drives a load request for hold cycles. When measure is set (a single
   // cycle pulse is expected), it also counts how long busy stays high and
   // compares that with N_in+1.
   task automatic applyStimulus(input int inst, input int value, input int hold,
                                input bit measure);
      int cnt;
      bin_v[inst]  = 14'(value);
      load_v[inst] = 1'b1;
      repeat (hold) @(negedge clk);
      load_v[inst] = 1'b0;
      if (measure) begin
         cnt = 0;
         while (busy_w[inst] === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
         end
         checkOutput($sformatf("busylen%0d", inst), 32'(cnt), 32'(NIN[inst] + 1));
      end
   endtask

   // Directed scenarios first, then a randomized mix of loads, held loads
   // and occasional resets in the middle of a conversion.
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      chk_en    = 1'b0;
      rst       = 1'b1;
      bin_v[0]  = '0;
      bin_v[1]  = '0;
      load_v[0] = 1'b0;
      load_v[1] = 1'b0;

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;
      repeat (20) @(negedge clk);

      applyStimulus(0, 1023, 1, 1'b1);
      repeat (20) @(negedge clk);

      applyStimulus(0, 512, 1, 1'b0);
      repeat (3) @(negedge clk);
      bin_v[0]  = 14'd7;
      load_v[0] = 1'b1;
      @(negedge clk);
      load_v[0] = 1'b0;
      waitIdle(0);
      repeat (20) @(negedge clk);

      applyStimulus(0, 999, 1, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (18) @(negedge clk);
      applyStimulus(0, 5, 1, 1'b1);
      repeat (20) @(negedge clk);

      applyStimulus(1, 12345, 1, 1'b1);
      repeat (20) @(negedge clk);
      applyStimulus(1, 16383, 1, 1'b1);
      repeat (18) @(negedge clk);
      applyStimulus(1, 10000, 1, 1'b1);
      repeat (18) @(negedge clk);
      applyStimulus(1, 9999, 1, 1'b1);
      repeat (18) @(negedge clk);
      applyStimulus(0, 42, 1, 1'b1);
      repeat (18) @(negedge clk);
      applyStimulus(0, 0, 1, 1'b1);
      repeat (18) @(negedge clk);

      for (int it = 0; it < 40; it++) begin
         int inst;
         int val;
         inst = int'($urandom_range(0, 1));
         val  = (inst == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 16383));
         applyStimulus(inst, val, int'($urandom_range(1, 30)), 1'b0);
         if ($urandom_range(0, 7) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         waitIdle(inst);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
